alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares the single combinational 32-bit ALU between two requesters (req 0 = main datapath,
//  req 1 = auxiliary unit, e.g. branch/address compare). Accepts one operation at a time via
//  valid/ready, drives the ALU operand/op bus, captures result and zero flag, and returns them
//  to the granted requester through its own valid/ready response channel.
// PARAMETERS
//  W    32  operand/result width
//  OPW  3   ALU opcode width
// PORTS
//  clk            in   1    clock, all state updates on rising edge
//  rst            in   1    reset, synchronous, active-high
//  req_valid      in   2    per-requester request valid, bit i = requester i
//  req_ready      out  2    per-requester request accepted this cycle
//  req_a0/req_a1  in   W    operand a, requester 0/1
//  req_b0/req_b1  in   W    operand b, requester 0/1
//  req_op0/req_op1 in  OPW  ALU opcode, requester 0/1
//  rsp_valid      out  2    per-requester response valid
//  rsp_ready      in   2    per-requester response consumed
//  rsp_result     out  W    captured ALU result (shared by both response channels)
//  rsp_zero       out  1    captured zero flag
//  rsp_err        out  1    1 = opcode was illegal; result forced 0
//  alu_a, alu_b   out  W    to ALU a/b
//  alu_op         out  OPW  to ALU op
//  alu_result     in   W    from ALU result
//  alu_zero       in   1    from ALU zero
// BEHAVIOUR
//  - Clock clk, reset rst synchronous active-high. Reset: state=IDLE, req_ready=0, rsp_valid=0,
//    rsp_result=0, rsp_zero=0, rsp_err=0, alu_a=alu_b=0, alu_op=0, last_grant=1 (req 0 favoured).
//  - FSM IDLE -> EXEC -> RESP -> IDLE.
//  - IDLE: if any req_valid, grant g: only one valid -> that one; both -> requester != last_grant
//    (round-robin). req_ready[g]=1 combinationally this cycle only; other bit 0. On edge:
//    latch a/b/op of g into operand regs, store g, go EXEC. No valid -> stay IDLE, req_ready=0.
//  - req_ready is 0 in EXEC and RESP; requests there are held off, never dropped by the arbiter.
//  - alu_a/alu_b/alu_op are registered: always equal operand regs (stable through EXEC, RESP).
//  - EXEC (1 cycle): ALU settles; on edge capture alu_result->rsp_result, alu_zero->rsp_zero,
//    go RESP. Legal ops: 000 add, 001 and, 010 xor, 100 sub, 101 or, 110 {b[15:0],16'h0}.
//    Illegal op (011,111): ALU output ignored; rsp_result=0, rsp_zero=1, rsp_err=1.
//  - RESP: rsp_valid[g]=1, other bit 0; result/zero/err held stable. On rsp_ready[g]: edge ->
//    rsp_valid=0, last_grant=g, IDLE. rsp_ready[!g] ignored. Stall indefinitely otherwise.
//  - Latency: accept at edge N -> rsp_valid high from cycle N+2. Max throughput 1 op / 3 cycles.
//  - last_grant updates only at response completion, so a requester whose op is in flight cannot
//    win the next arbitration over a waiting peer.
//  - Reset mid-operation (EXEC or RESP): transaction discarded, no rsp_valid, return to IDLE with
//    reset values; requester must re-issue.
//  - rsp_result etc. retain last value in IDLE (do not clear), only rsp_valid qualifies them.
// TESTING
//  1 rst=1 2 cycles -> all outputs 0, req_ready=00; req_valid=01 a=5 b=3 op=000 -> req_ready=01,
//    two cycles later rsp_valid=01, rsp_result=8, rsp_zero=0, rsp_err=0.
//  2 req 1: a=7 b=7 op=100 -> rsp_valid=10, result=0, zero=1; rsp_ready held 0 for 5 cycles ->
//    rsp_valid/result stable; rsp_ready=01 (wrong bit) -> no completion.
//  3 both valid continuously after reset -> grants alternate 0,1,0,1; each req_ready pulse
//    1 cycle; no two grants closer than 3 cycles.
//  4 op=011 a=1 b=1 -> rsp_result=0, rsp_zero=1, rsp_err=1; next legal op clears rsp_err.
//  5 op=110 b=32'h0000_ABCD -> rsp_result=32'hABCD_0000; op=010 a=b=FFFF_FFFF -> result 0 zero 1.
//  6 rst asserted in EXEC and separately in RESP -> next cycle IDLE, rsp_valid=00, no response;
//    following request served normally, req 0 wins a tie.

Source files
------------

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Shares one external combinational ALU between two requesters. Requester 0
//   is the main datapath, requester 1 an auxiliary unit. One operation is in
//   flight at a time: IDLE accepts a request, EXEC lets the ALU settle and
//   captures its outputs, and RESP presents the result to the granted requester
//   until that requester consumes it.
//
//   Ports
//     clk, rst                 clock, synchronous active-high reset
//     req_valid/req_ready[1:0] per-requester request handshake (bit i = req i)
//     req_a0/b0/op0            operands and opcode from requester 0
//     req_a1/b1/op1            operands and opcode from requester 1
//     rsp_valid/rsp_ready[1:0] per-requester response handshake
//     rsp_result/zero/err      captured result, zero flag, illegal-op flag
//     alu_a/alu_b/alu_op       registered operand/opcode bus to the ALU
//     alu_result/alu_zero      ALU outputs
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int W   = 32,
    parameter int OPW = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [W-1:0]   req_a0,
    input  logic [W-1:0]   req_a1,
    input  logic [W-1:0]   req_b0,
    input  logic [W-1:0]   req_b1,
    input  logic [OPW-1:0] req_op0,
    input  logic [OPW-1:0] req_op1,
    output logic [1:0]     rsp_valid,
    input  logic [1:0]     rsp_ready,
    output logic [W-1:0]   rsp_result,
    output logic           rsp_zero,
    output logic           rsp_err,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic [OPW-1:0] alu_op,
    input  logic [W-1:0]   alu_result,
    input  logic           alu_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           grant_q, grant_d;
    logic           last_grant_q, last_grant_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [OPW-1:0] op_q, op_d;
    logic [W-1:0]   rsp_result_q, rsp_result_d;
    logic           rsp_zero_q, rsp_zero_d;
    logic           rsp_err_q, rsp_err_d;

    // Opcodes x11 (011, 111) have no ALU function assigned.
    function automatic logic op_illegal(input logic [OPW-1:0] op);
        return (op[1:0] == 2'b11);
    endfunction

    // Round-robin pick: a lone requester always wins; on a tie the requester
    // that did not complete last goes next.
    function automatic logic pick_grant(input logic [1:0] vld, input logic last);
        if (vld == 2'b11) begin
            return ~last;
        end
        return vld[1];
    endfunction

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_err_d    = rsp_err_q;
        req_ready    = 2'b00;
        rsp_valid    = 2'b00;

        case (state_q)
            IDLE: begin
                if (req_valid != 2'b00) begin
                    grant_d = pick_grant(req_valid, last_grant_q);
                    req_ready[grant_d] = 1'b1;
                    a_d     = grant_d ? req_a1  : req_a0;
                    b_d     = grant_d ? req_b1  : req_b0;
                    op_d    = grant_d ? req_op1 : req_op0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (op_illegal(op_q)) begin
                    rsp_result_d = '0;
                    rsp_zero_d   = 1'b1;
                    rsp_err_d    = 1'b1;
                end else begin
                    rsp_result_d = alu_result;
                    rsp_zero_d   = alu_zero;
                    rsp_err_d    = 1'b0;
                end
                state_d = RESP;
            end
            RESP: begin
                rsp_valid[grant_q] = 1'b1;
                // Only the granted requester's ready completes the response;
                // last_grant moves here so an in-flight requester cannot
                // jump ahead of a waiting peer.
                if (rsp_ready[grant_q]) begin
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_op     = op_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_a0, req_a1, req_b0, req_b1;
    logic [2:0]  req_op0, req_op1;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic        rsp_err;
    logic [31:0] alu_a, alu_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_zero;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.W(32), .OPW(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a0     (req_a0),
        .req_a1     (req_a1),
        .req_b0     (req_b0),
        .req_b1     (req_b1),
        .req_op0    (req_op0),
        .req_op1    (req_op1),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_zero   (alu_zero)
    );

    // Reference ALU; illegal opcodes produce junk that the arbiter must ignore.
    always_comb begin
        case (alu_op)
            3'b000:  alu_result = alu_a + alu_b;
            3'b001:  alu_result = alu_a & alu_b;
            3'b010:  alu_result = alu_a ^ alu_b;
            3'b100:  alu_result = alu_a - alu_b;
            3'b101:  alu_result = alu_a | alu_b;
            3'b110:  alu_result = {alu_b[15:0], 16'h0000};
            default: alu_result = 32'hDEAD_BEEF;
        endcase
    end
    assign alu_zero = (alu_op[1:0] == 2'b11) ? 1'b0 : (alu_result == 32'h0);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request from requester r, check the grant, and let it be
    // accepted on the next edge. Returns with the DUT in EXEC.
    task automatic issue(input int r, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input logic [1:0] exp_ready, input string tag);
        if (r == 0) begin
            req_a0 = a; req_b0 = b; req_op0 = op; req_valid = 2'b01;
        end else begin
            req_a1 = a; req_b1 = b; req_op1 = op; req_valid = 2'b10;
        end
        #1;
        chk({tag, "_req_ready"}, {30'b0, req_ready}, {30'b0, exp_ready});
        step();
        req_valid = 2'b00;
    endtask

    // From EXEC: move to RESP, check the response, consume it.
    task automatic finish_rsp(input int r, input logic [31:0] exp_res, input logic exp_zero,
                              input logic exp_err, input string tag);
        logic [1:0] bit_r;
        bit_r = (r == 0) ? 2'b01 : 2'b10;
        step();
        chk({tag, "_rsp_valid"},  {30'b0, rsp_valid}, {30'b0, bit_r});
        chk({tag, "_rsp_result"}, rsp_result, exp_res);
        chk({tag, "_rsp_zero"},   {31'b0, rsp_zero}, {31'b0, exp_zero});
        chk({tag, "_rsp_err"},    {31'b0, rsp_err},  {31'b0, exp_err});
        rsp_ready = bit_r;
        step();
        rsp_ready = 2'b00;
        chk({tag, "_rsp_done"}, {30'b0, rsp_valid}, 32'h0);
    endtask

    initial begin
        logic [1:0] exp_rdy, exp_vld;

        rst = 1'b1;
        req_valid = 2'b00; rsp_ready = 2'b00;
        req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0;
        req_op0 = '0; req_op1 = '0;

        // Test 1: reset values, then a single add from requester 0
        step();
        step();
        chk("rst_req_ready",  {30'b0, req_ready}, 32'h0);
        chk("rst_rsp_valid",  {30'b0, rsp_valid}, 32'h0);
        chk("rst_rsp_result", rsp_result, 32'h0);
        chk("rst_rsp_zero",   {31'b0, rsp_zero}, 32'h0);
        chk("rst_rsp_err",    {31'b0, rsp_err}, 32'h0);
        chk("rst_alu_a",      alu_a, 32'h0);
        chk("rst_alu_b",      alu_b, 32'h0);
        chk("rst_alu_op",     {29'b0, alu_op}, 32'h0);
        rst = 1'b0;

        issue(0, 32'd5, 32'd3, 3'b000, 2'b01, "t1");
        chk("t1_exec_ready", {30'b0, req_ready}, 32'h0);
        chk("t1_exec_valid", {30'b0, rsp_valid}, 32'h0);
        chk("t1_alu_a",      alu_a, 32'd5);
        chk("t1_alu_b",      alu_b, 32'd3);
        finish_rsp(0, 32'd8, 1'b0, 1'b0, "t1");
        chk("t1_result_retained", rsp_result, 32'd8);

        // Test 2: requester 1 sub, response stalls and wrong-bit ready
        issue(1, 32'd7, 32'd7, 3'b100, 2'b10, "t2");
        step();
        chk("t2_rsp_valid", {30'b0, rsp_valid}, 32'h2);
        chk("t2_result",    rsp_result, 32'h0);
        chk("t2_zero",      {31'b0, rsp_zero}, 32'h1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t2_stall_valid",  {30'b0, rsp_valid}, 32'h2);
            chk("t2_stall_result", rsp_result, 32'h0);
        end
        rsp_ready = 2'b01;
        step();
        chk("t2_wrong_ready", {30'b0, rsp_valid}, 32'h2);
        rsp_ready = 2'b10;
        step();
        rsp_ready = 2'b00;
        chk("t2_done", {30'b0, rsp_valid}, 32'h0);

        // Test 3: both requesters valid continuously after reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_a0 = 32'd10; req_b0 = 32'd1; req_op0 = 3'b000;
        req_a1 = 32'd20; req_b1 = 32'd5; req_op1 = 3'b100;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        #1;
        for (int i = 0; i < 12; i++) begin
            exp_rdy = 2'b00;
            exp_vld = 2'b00;
            if (i % 3 == 0) exp_rdy = ((i / 3) % 2 == 0) ? 2'b01 : 2'b10;
            if (i % 3 == 2) exp_vld = ((i / 3) % 2 == 0) ? 2'b01 : 2'b10;
            chk("t3_req_ready", {30'b0, req_ready}, {30'b0, exp_rdy});
            chk("t3_rsp_valid", {30'b0, rsp_valid}, {30'b0, exp_vld});
            if (i % 3 == 2)
                chk("t3_result", rsp_result, ((i / 3) % 2 == 0) ? 32'd11 : 32'd15);
            step();
        end
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        #1;
        chk("t3_idle", {30'b0, rsp_valid}, 32'h0);

        // Test 4: illegal opcodes, then a legal op clears the error flag
        issue(0, 32'd1, 32'd1, 3'b011, 2'b01, "t4a");
        finish_rsp(0, 32'h0, 1'b1, 1'b1, "t4a");
        issue(0, 32'd1, 32'd1, 3'b000, 2'b01, "t4b");
        finish_rsp(0, 32'd2, 1'b0, 1'b0, "t4b");
        issue(1, 32'd4, 32'd9, 3'b111, 2'b10, "t4c");
        finish_rsp(1, 32'h0, 1'b1, 1'b1, "t4c");

        // Test 5: shift-left-16 and xor-to-zero
        issue(0, 32'h1234_5678, 32'h0000_ABCD, 3'b110, 2'b01, "t5a");
        finish_rsp(0, 32'hABCD_0000, 1'b0, 1'b0, "t5a");
        issue(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b010, 2'b10, "t5b");
        finish_rsp(1, 32'h0, 1'b1, 1'b0, "t5b");
        issue(0, 32'hF0F0_0000, 32'h0F0F_0001, 3'b101, 2'b01, "t5c");
        finish_rsp(0, 32'hFFFF_0001, 1'b0, 1'b0, "t5c");
        issue(1, 32'hF0F0_0000, 32'h0F0F_0001, 3'b001, 2'b10, "t5d");
        finish_rsp(1, 32'h0, 1'b1, 1'b0, "t5d");

        // Test 6: reset in EXEC, reset in RESP, then a tie goes to requester 0
        issue(0, 32'd3, 32'd4, 3'b000, 2'b01, "t6a");
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6a_rsp_valid", {30'b0, rsp_valid}, 32'h0);
        chk("t6a_req_ready", {30'b0, req_ready}, 32'h0);
        chk("t6a_alu_a",     alu_a, 32'h0);
        chk("t6a_result",    rsp_result, 32'h0);
        step();
        chk("t6a_no_rsp", {30'b0, rsp_valid}, 32'h0);

        issue(1, 32'd6, 32'd2, 3'b100, 2'b10, "t6b");
        step();
        chk("t6b_in_resp", {30'b0, rsp_valid}, 32'h2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6b_rsp_valid", {30'b0, rsp_valid}, 32'h0);
        chk("t6b_result",    rsp_result, 32'h0);
        step();
        chk("t6b_no_rsp", {30'b0, rsp_valid}, 32'h0);

        req_a0 = 32'd9; req_b0 = 32'd6; req_op0 = 3'b100;
        req_a1 = 32'd1; req_b1 = 32'd1; req_op1 = 3'b000;
        req_valid = 2'b11;
        #1;
        chk("t6c_tie_ready", {30'b0, req_ready}, 32'h1);
        step();
        req_valid = 2'b00;
        finish_rsp(0, 32'd3, 1'b0, 1'b0, "t6c");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
